dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between the core LSU (req 0) and an external
//  loader/debug master (req 1, valid/ready). Core has priority; an age counter
//  guarantees ext forward progress. Routes the 1-cycle-latency read data back to
//  the winning requester. Sits between the LSU / debug master and the data memory.
// PARAMETERS
//  MAX_WAIT  8  cycles ext may wait before it takes priority over core (1..255)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  c_req        in   1   core access request (lsu_en & (load|store))
//  c_addr       in   32  core byte address
//  c_we         in   4   core byte write enables (0 = read)
//  c_wdata      in   32  core store data
//  c_gnt        out  1   core access issued this cycle; 0 while c_req -> core stalls
//  c_rdata      out  32  raw memory read data, valid cycle after granted core read
//  x_valid      in   1   ext request valid
//  x_ready      out  1   ext request accepted this cycle
//  x_addr       in   32  ext byte address
//  x_we         in   4   ext byte write enables (0 = read)
//  x_wdata      in   32  ext store data
//  x_rsp_valid  out  1   ext read data valid (cycle after accepted ext read)
//  x_rdata      out  32  ext read data
//  d_addr       out  32  memory address
//  d_we         out  4   memory byte write enables
//  d_wr_data    out  32  memory write data
//  d_rd_data    in   32  memory read data, 1 cycle after address
//  stall_cnt    out  32  core-denied cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Grant (combinational, same cycle): ext_pri = (age == MAX_WAIT).
//    x_ready = x_valid & (~c_req | ext_pri); c_gnt = c_req & ~x_ready.
//  - Both request, age < MAX_WAIT -> core wins, age += 1. Age saturates at MAX_WAIT.
//  - x_valid & ~x_ready -> age += 1 (sat); x_ready or ~x_valid -> age <= 0 next cycle.
//  - Ext request fields must stay stable while x_valid & ~x_ready (valid/ready rule);
//    ext may not drop x_valid before x_ready. Core holds c_* while c_gnt = 0.
//  - Mux: winner's addr/we/wdata drive d_*; no winner -> d_we = 0, d_addr = c_addr,
//    d_wr_data = c_wdata.
//  - Response routing: register rd_owner and rd_pend on every granted read (we == 0).
//    x_rsp_valid = rd_pend & (rd_owner == OWN_EXT). x_rdata = c_rdata = d_rd_data.
//    Writes produce no response. Back-to-back grants alternate freely; no bubble.
//  - Reset (rst_n low, any time): age = 0, rd_pend = 0, rd_owner = OWN_CORE,
//    stall_cnt = 0; x_rsp_valid = 0 immediately; in-flight response dropped.
//    Combinational outputs follow inputs during reset with age = 0.
//  - No FSM beyond 2 owner states; no request queueing; at most 1 read in flight.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: stall_cnt += 1 each cycle c_req & ~c_gnt, wraps at 2^32.
//  Not defined: stall_cnt tied to 32'h0, no counter flops. Port exists either way.
// STRUCTURE
//  defines.svh: typedef enum logic {OWN_CORE, OWN_EXT} dmem_owner_t.
//  Sub-module dmem_arb_age: saturating age counter (inc/clr/sat -> ext_pri).
//  Grant, mux, response routing and stats stay in dmem_arbiter.
// TESTING
//  1 Core-only: c_req read 0x100, mem[0x100]=0xDEADBEEF -> c_gnt=1, next c_rdata=DEADBEEF, x_rsp_valid=0.
//  2 Ext-only: x_valid write 0x200 we=4'hF data=0x12345678 -> x_ready same cycle, mem updated, no rsp.
//  3 Contention MAX_WAIT=8: c_req and x_valid held -> core granted 8 cycles, cycle 9 x_ready=1, c_gnt=0; age=0 after.
//  4 Interleave: core read A then ext read B back-to-back -> c_rdata=mem[A] cycle 2, x_rsp_valid+mem[B] cycle 3.
//  5 Reset mid-op: ext read accepted, rst_n low next cycle -> x_rsp_valid=0, age=0, stall_cnt=0.
//  6 DMEM_ARB_STATS_EN: 3 core-denied cycles -> stall_cnt=3; undefined build -> stall_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: read-response owner encoding
// and the width of the ext-request age counter.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } dmem_owner_t;

  // Wide enough for MAX_WAIT up to 255.
  localparam int AGE_W = 8;

endpackage

// File: rtl/dmem_arb_age.sv
// Saturating age counter for the ext requester. Once it reaches MAX_WAIT the
// ext request overrides core priority until it is accepted.
module dmem_arb_age
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic ext_pri
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (clr) begin
      age <= '0;
    end else if (inc && (age != AGE_SAT)) begin
      age <= age + 1'b1;
    end
  end

  assign ext_pri = (age == AGE_SAT);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core LSU has priority, an aged ext master takes over
// after MAX_WAIT denied cycles. Optional stall counter under DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic [3:0]  c_we,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic [31:0] c_rdata,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [31:0] x_addr,
  input  logic [3:0]  x_we,
  input  logic [31:0] x_wdata,
  output logic        x_rsp_valid,
  output logic [31:0] x_rdata,
  output logic [31:0] d_addr,
  output logic [3:0]  d_we,
  output logic [31:0] d_wr_data,
  input  logic [31:0] d_rd_data,
  output logic [31:0] stall_cnt
);

  logic        ext_pri;
  logic        rd_pend;
  dmem_owner_t rd_owner;
  logic        c_rd_issue;
  logic        x_rd_issue;

  dmem_arb_age #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (x_valid & ~x_ready),
    .clr     (x_ready | ~x_valid),
    .ext_pri (ext_pri)
  );

  assign x_ready = x_valid & (~c_req | ext_pri);
  assign c_gnt   = c_req & ~x_ready;

  // NOTE: combinational blocks assign every output a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    d_addr    = c_addr;
    d_we      = '0;
    d_wr_data = c_wdata;
    if (x_ready) begin
      d_addr    = x_addr;
      d_we      = x_we;
      d_wr_data = x_wdata;
    end else if (c_gnt) begin
      d_we = c_we;
    end
  end

  assign c_rd_issue = c_gnt & (c_we == 4'h0);
  assign x_rd_issue = x_ready & (x_we == 4'h0);

  // Memory has a fixed 1-cycle read latency, so one pending flag suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CORE;
    end else begin
      rd_pend <= c_rd_issue | x_rd_issue;
      if (x_rd_issue) begin
        rd_owner <= OWN_EXT;
      end else if (c_rd_issue) begin
        rd_owner <= OWN_CORE;
      end
    end
  end

  assign x_rsp_valid = rd_pend & (rd_owner == OWN_EXT);
  assign x_rdata     = d_rd_data;
  assign c_rdata     = d_rd_data;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (c_req && !c_gnt) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected read data,
// a monitor pops it whenever a response is due or presented.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req;
  logic [31:0] c_addr;
  logic [3:0]  c_we;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic [31:0] c_rdata;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] x_addr;
  logic [3:0]  x_we;
  logic [31:0] x_wdata;
  logic        x_rsp_valid;
  logic [31:0] x_rdata;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wr_data;
  logic [31:0] d_rd_data;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  bit no_rsp = 1'b0;
  logic [31:0] core_q[$];
  logic [31:0] ext_q[$];

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_req       (c_req),
    .c_addr      (c_addr),
    .c_we        (c_we),
    .c_wdata     (c_wdata),
    .c_gnt       (c_gnt),
    .c_rdata     (c_rdata),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .x_addr      (x_addr),
    .x_we        (x_we),
    .x_wdata     (x_wdata),
    .x_rsp_valid (x_rsp_valid),
    .x_rdata     (x_rdata),
    .d_addr      (d_addr),
    .d_we        (d_we),
    .d_wr_data   (d_wr_data),
    .d_rd_data   (d_rd_data),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Simple word memory with 1-cycle read latency and byte enables.
  logic [31:0] mem [0:255];
  bit preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'hDEADBEEF;  // 0x100
      mem[8'h81] <= 32'h11111111;  // 0x204
      preloaded  <= 1'b1;
    end else begin
      d_rd_data <= mem[d_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (d_we[b]) mem[d_addr[9:2]][8*b +: 8] <= d_wr_data[8*b +: 8];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_stall(input string nm);
`ifdef DMEM_ARB_STATS_EN
    check(nm, stall_cnt, 32'(exp_stall));
`else
    check(nm, stall_cnt, 32'h0);
`endif
  endtask

  // One clock of stimulus: inputs already driven; check grants, queue responses.
  task automatic cycle(input logic ec, input logic ex, input logic [31:0] ec_data,
                       input logic [31:0] ex_data, input string nm);
    @(negedge clk);
    check({nm, " c_gnt"}, {31'h0, c_gnt}, {31'h0, ec});
    check({nm, " x_ready"}, {31'h0, x_ready}, {31'h0, ex});
    if (ec && c_we == 4'h0) core_q.push_back(ec_data);
    if (ex && x_we == 4'h0 && !no_rsp) ext_q.push_back(ex_data);
    if (c_req && !ec) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 1'b0; c_we = 4'h0; x_valid = 1'b0; x_we = 4'h0;
  endtask

  task automatic set_core(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    c_req = 1'b1; c_addr = a; c_we = we; c_wdata = wd;
  endtask

  task automatic set_ext(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    x_valid = 1'b1; x_addr = a; x_we = we; x_wdata = wd;
  endtask

  // Both held: core wins MAX_WAIT cycles, then ext wins once.
  task automatic contend(input logic [31:0] c_exp, input logic [31:0] x_exp, input string nm);
    for (int i = 0; i < MAX_WAIT; i++) cycle(1'b1, 1'b0, c_exp, 32'h0, nm);
    cycle(1'b0, 1'b1, 32'h0, x_exp, {nm, " aged"});
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    core_q.delete();
    ext_q.delete();
    exp_stall = 0;
    idle();
    #2;
    check("reset x_rsp_valid", {31'h0, x_rsp_valid}, 32'h0);
    check_stall("reset stall_cnt");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: response data is due 1 cycle after a granted read.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (core_q.size() > 0) check("c_rdata", c_rdata, core_q.pop_front());
      if (x_rsp_valid) begin
        if (ext_q.size() == 0) check("x_rsp_valid unexpected", 32'h1, 32'h0);
        else check("x_rdata", x_rdata, ext_q.pop_front());
      end else if (ext_q.size() > 0) begin
        check("x_rsp_valid missing", 32'h0, 32'h1);
        void'(ext_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    c_addr = '0; c_wdata = '0; x_addr = '0; x_wdata = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset x_rsp_valid", {31'h0, x_rsp_valid}, 32'h0);
    check_stall("reset stall_cnt");
    set_core(32'h100, 4'h0, 32'h0);
    #1;
    check("reset c_gnt follows c_req", {31'h0, c_gnt}, 32'h1);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Core-only read
    set_core(32'h100, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, "core read");
    idle();
    #1;
    check("idle d_we", {28'h0, d_we}, 32'h0);
    check("idle d_addr", d_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");

    // Ext-only writes (full word, then low half) and read-back
    set_ext(32'h200, 4'hF, 32'h12345678);
    cycle(1'b0, 1'b1, 32'h0, 32'h0, "ext write");
    set_ext(32'h204, 4'b0011, 32'hAAAA5555);
    cycle(1'b0, 1'b1, 32'h0, 32'h0, "ext byte write");
    set_ext(32'h200, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0, 32'h12345678, "ext read 200");
    set_ext(32'h204, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0, 32'h11115555, "ext read 204");
    idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");

    // Contention: aging, and age cleared after the ext grant
    set_core(32'h100, 4'h0, 32'h0);
    set_ext(32'h300, 4'hF, 32'hCAFEF00D);
    contend(32'hDEADBEEF, 32'h0, "contend1");
    set_ext(32'h200, 4'h0, 32'h0);
    contend(32'hDEADBEEF, 32'h12345678, "contend2");
    idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
    check_stall("stall after contention");

    // Interleave: core read A then ext read B back-to-back
    set_core(32'h100, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, "interleave core");
    idle();
    set_ext(32'h300, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, "interleave ext");
    set_core(32'h200, 4'h0, 32'h0);
    idle();
    set_core(32'h200, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, 32'h12345678, 32'h0, "interleave core2");
    idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");

    // Reset with an ext read response in flight
    set_ext(32'h200, 4'h0, 32'h0);
    no_rsp = 1'b1;
    cycle(1'b0, 1'b1, 32'h0, 32'h0, "ext read before reset");
    no_rsp = 1'b0;
    pulse_reset();

    // Stall counting: three aged ext wins deny core three cycles
    set_core(32'h100, 4'h0, 32'h0);
    set_ext(32'h308, 4'hF, 32'h0BADF00D);
    for (int r = 0; r < 3; r++) contend(32'hDEADBEEF, 32'h0, "stats");
    idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
    check_stall("stall_cnt three denials");

    // Reset mid-aging: after reset ext must wait a full MAX_WAIT again
    set_core(32'h100, 4'h0, 32'h0);
    set_ext(32'h308, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, "pre-reset age");
    pulse_reset();
    set_core(32'h100, 4'h0, 32'h0);
    set_ext(32'h308, 4'h0, 32'h0);
    contend(32'hDEADBEEF, 32'h0BADF00D, "post-reset age");
    idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
    cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
    check_stall("stall_cnt after reset run");

    check("core_q drained", 32'(core_q.size()), 32'h0);
    check("ext_q drained", 32'(ext_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
